fifo_loader: RTL and testbench
==============================

# fifo_loader

Write-side controller for the on-chip activation/weight FIFOs. On a `start` pulse it streams `length` consecutive words from a synchronous-read buffer RAM (1-cycle read latency) into a FIFO's write port, honouring `fifo_full` backpressure without dropping or duplicating words. It sits between the feature-map buffer and each systolic-array input FIFO.

## Interface
- `data_size`, 8, word width (matches FIFO `data_size`)
- `addr_width`, 10, buffer RAM address width
- `len_width`, 8, burst length counter width
- `clear_on_start`, 1, if 1, pulse `fifo_clear` for one cycle before streaming

- `w_clk` in 1: clock; also drives the FIFO write side
- `reset` in 1: synchronous, active-high
- `start` in 1: burst request, sampled only in IDLE
- `base_addr` in `addr_width`: first RAM address, latched with `start`
- `length` in `len_width`: words to transfer, latched with `start`
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` pulses (inclusive)
- `done` out 1: one-cycle pulse at burst completion
- `words_written` out `len_width`: words pushed in the current/last burst
- `mem_rd_en` out 1: RAM read strobe
- `mem_addr` out `addr_width`: RAM read address
- `mem_rdata` in `data_size`: RAM data, valid the cycle after `mem_rd_en`
- `fifo_w_en` out 1: FIFO write enable
- `fifo_data` out `data_size`: FIFO write data
- `fifo_full` in 1: FIFO full flag
- `fifo_clear` out 1: FIFO clear pulse

## Operation
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE: `start`=1 latches `base_addr`/`length`, zeroes the issue and write counters, then moves to CLEAR if `clear_on_start`=1, otherwise to STREAM. If `length`=0, it goes straight to DONE. `start` in any other state is ignored.
- CLEAR: `fifo_clear`=1 for exactly one cycle, then STREAM.
- STREAM issue rule: `mem_rd_en`=1 when issued<length, hold register empty and `fifo_full`=0.
  - `mem_addr` = (base + issued) mod 2^`addr_width`, so it wraps.
  - issued increments on each read.
- STREAM write rule, in priority order:
  - If the hold register is full and `fifo_full`=0: write the hold word and empty the hold register.
  - Else if a read was issued last cycle and `fifo_full`=0: `fifo_w_en`=1 and `fifo_data`=`mem_rdata`, combinational pass-through.
  - Else if a read was issued last cycle and `fifo_full`=1: capture `mem_rdata` into the hold register.
- `fifo_w_en` is never 1 while `fifo_full`=1. Every word is written exactly once and in address order.
- When written==length, go to DONE. DONE pulses `done` for one cycle, then returns to IDLE.
- `words_written` holds its final value until the next accepted `start`.
- A reset in any state, including mid-burst, returns to IDLE and discards the hold register and in-flight read. The FIFO contents are left to the consumer.

## Timing
- Reset values: `busy`=0, `done`=0, `words_written`=0, `mem_rd_en`=0, `mem_addr`=0, `fifo_w_en`=0, `fifo_data`=0, `fifo_clear`=0; hold register empty.
- `start` at cycle 0, `clear_on_start`=0: first `mem_rd_en` at cycle 1, first `fifo_w_en` at cycle 2.
- With `clear_on_start`=1, each of those moves one cycle later.
- Steady-state throughput is 1 word/cycle when no backpressure is applied.
- Last write at cycle k: `done`=1 at cycle k+1, `busy`=0 at cycle k+2.
- `length`=0: `done` at cycle 1 (cycle 2 with clear) and no RAM or FIFO writes.
- Full asserted: at most one in-flight word lands in the hold register. Issue stalls until the hold register drains.
- Full deasserts at cycle m: hold word written at m. If the hold register was then empty, the next issue may occur in the same cycle m.

## Structure
- Shared package `fifo_loader_pkg` holds the state enum (IDLE, CLEAR, STREAM, DONE) and default widths.
- One sub-module, `fifo_loader_hold`, the 1-entry hold register. Ports: load, unload, data in/out, valid.

## Test plan
- `base_addr`=0x010, `length`=4, `clear_on_start`=0, no backpressure:
  - `mem_addr` 0x010–0x013 at cycles 1–4.
  - FIFO receives RAM[0x010..0x013] at cycles 2–5.
  - `done` at cycle 6; `words_written`=4.
- `length`=8, `fifo_full` forced high at cycles 3–6:
  - Exactly one hold capture occurs.
  - No `fifo_w_en` while full.
  - All 8 words arrive in order with no duplicates; `done` follows the last write.
- `length`=0: `done` at cycle 1, zero `mem_rd_en` and zero `fifo_w_en`, `busy` high only in cycle 1.
- `base_addr`=0x3FE, `length`=4, `addr_width`=10: `mem_addr` sequence is 0x3FE, 0x3FF, 0x000, 0x001.
- `clear_on_start`=1, `length`=2: `fifo_clear`=1 at cycle 1 only, then reads at cycles 2–3.
- Reset asserted at the 3rd write of a 6-word burst: next cycle all outputs are at reset values. A fresh `start` of 2 words then completes normally with `words_written`=2.
- `start` pulsed mid-burst: ignored, with no change to the address sequence or counters.

Source files
------------

// File: rtl/fifo_loader_pkg.sv
// Shared types and default widths for the FIFO write-side loader.
package fifo_loader_pkg;

   localparam int DEF_DATA_SIZE  = 8;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_LEN_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/fifo_loader_hold.sv
// One-entry skid register that parks a RAM word which arrived while the FIFO was full.
module fifo_loader_hold
   import fifo_loader_pkg::*;
#(
   parameter int data_size = DEF_DATA_SIZE
) (
   input  logic                 w_clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 unload,
   input  logic [data_size-1:0] data_in,
   output logic [data_size-1:0] data_out,
   output logic                 valid
);

   logic [data_size-1:0] data_q;

   // Load wins over unload; the loader never requests both in one cycle.
   always_ff @(posedge w_clk) begin
      if (reset) begin
         valid  <= 1'b0;
         data_q <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         data_q <= data_in;
      end else if (unload) begin
         valid  <= 1'b0;
      end
   end

   assign data_out = data_q;

endmodule

// File: rtl/fifo_loader.sv
// Streams a burst of words from a 1-cycle-latency buffer RAM into a FIFO write port,
// absorbing fifo_full backpressure with a single hold entry.
module fifo_loader
   import fifo_loader_pkg::*;
#(
   parameter int data_size      = DEF_DATA_SIZE,
   parameter int addr_width     = DEF_ADDR_WIDTH,
   parameter int len_width      = DEF_LEN_WIDTH,
   parameter bit clear_on_start = 1'b1
) (
   input  logic                  w_clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_width-1:0] base_addr,
   input  logic [len_width-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [len_width-1:0]  words_written,
   output logic                  mem_rd_en,
   output logic [addr_width-1:0] mem_addr,
   input  logic [data_size-1:0]  mem_rdata,
   output logic                  fifo_w_en,
   output logic [data_size-1:0]  fifo_data,
   input  logic                  fifo_full,
   output logic                  fifo_clear
);

   localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

   state_t                state, next_state;
   logic [addr_width-1:0] base_q;
   logic [len_width-1:0]  len_q;
   logic [len_width-1:0]  issued;
   logic [len_width-1:0]  written;
   logic                  rd_pending;
   logic                  accept;
   logic                  hold_load, hold_unload, hold_valid;
   logic [data_size-1:0]  hold_data;

   assign accept = (state == IDLE) && start;

   always_ff @(posedge w_clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // A zero-length burst skips streaming entirely, after the optional clear.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (clear_on_start)      next_state = CLEAR;
               else if (length == '0)   next_state = DONE;
               else                     next_state = STREAM;
            end
         end
         CLEAR:   next_state = (len_q == '0) ? DONE : STREAM;
         STREAM:  if (fifo_w_en && ((written + LEN_ONE) == len_q)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // A parked word always drains before a fresh read is issued, which keeps words in order.
   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      fifo_clear  = (state == CLEAR);
      mem_rd_en   = 1'b0;
      fifo_w_en   = 1'b0;
      fifo_data   = '0;
      hold_load   = 1'b0;
      hold_unload = 1'b0;
      if (state == STREAM) begin
         mem_rd_en = (issued < len_q) && !hold_valid && !fifo_full;
         if (hold_valid && !fifo_full) begin
            fifo_w_en   = 1'b1;
            fifo_data   = hold_data;
            hold_unload = 1'b1;
         end else if (rd_pending && !fifo_full) begin
            fifo_w_en = 1'b1;
            fifo_data = mem_rdata;
         end else if (rd_pending && fifo_full) begin
            hold_load = 1'b1;
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (reset) begin
         base_q     <= '0;
         len_q      <= '0;
         issued     <= '0;
         written    <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= mem_rd_en;
         if (accept) begin
            base_q  <= base_addr;
            len_q   <= length;
            issued  <= '0;
            written <= '0;
         end else begin
            if (mem_rd_en) issued  <= issued + LEN_ONE;
            if (fifo_w_en) written <= written + LEN_ONE;
         end
      end
   end

   assign mem_addr      = base_q + addr_width'(issued);
   assign words_written = written;

   fifo_loader_hold #(
      .data_size (data_size)
   ) u_hold (
      .w_clk    (w_clk),
      .reset    (reset),
      .load     (hold_load),
      .unload   (hold_unload),
      .data_in  (mem_rdata),
      .data_out (hold_data),
      .valid    (hold_valid)
   );

endmodule

// File: tb/tb_fifo_loader.sv
// Self-checking bench for fifo_loader: two instances (with and without the start-of-burst
// clear) share stimulus; a behavioural RAM/FIFO model predicts every read, write and pulse.
module tb_fifo_loader;

   localparam int data_size  = 8;
   localparam int addr_width = 10;
   localparam int len_width  = 8;

   logic                  w_clk = 1'b0;
   logic                  reset, start, fifo_full, sel;
   logic [addr_width-1:0] base_addr;
   logic [len_width-1:0]  length;

   logic                  busy0, done0, rd_en0, w_en0, clr0;
   logic                  busy1, done1, rd_en1, w_en1, clr1;
   logic [len_width-1:0]  ww0, ww1;
   logic [addr_width-1:0] addr0, addr1;
   logic [data_size-1:0]  rdata0, rdata1, fdata0, fdata1;

   logic                  o_busy, o_done, o_rd_en, o_w_en, o_clr;
   logic [len_width-1:0]  o_ww;
   logic [addr_width-1:0] o_addr;
   logic [data_size-1:0]  o_fdata;

   logic [data_size-1:0]  ram [0:1023];

   int rd_cyc[$], rd_addr[$], wr_cyc[$], done_cyc[$], busy_cyc[$], clr_cyc[$];
   int viol_issue, viol_wen, viol_full, viol_data, capt;
   bit timed_out;
   logic [len_width-1:0] ww_final;
   logic [30:0] rst_snap;
   int n_checks, n_fail;

   always #5 w_clk = ~w_clk;

   always @(posedge w_clk) if (rd_en0) rdata0 <= ram[addr0];
   always @(posedge w_clk) if (rd_en1) rdata1 <= ram[addr1];

   assign o_busy  = sel ? busy1  : busy0;
   assign o_done  = sel ? done1  : done0;
   assign o_rd_en = sel ? rd_en1 : rd_en0;
   assign o_w_en  = sel ? w_en1  : w_en0;
   assign o_clr   = sel ? clr1   : clr0;
   assign o_ww    = sel ? ww1    : ww0;
   assign o_addr  = sel ? addr1  : addr0;
   assign o_fdata = sel ? fdata1 : fdata0;

   fifo_loader #(
      .data_size(data_size), .addr_width(addr_width), .len_width(len_width), .clear_on_start(1'b0)
   ) u_dut (
      .w_clk(w_clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy0), .done(done0), .words_written(ww0), .mem_rd_en(rd_en0), .mem_addr(addr0),
      .mem_rdata(rdata0), .fifo_w_en(w_en0), .fifo_data(fdata0), .fifo_full(fifo_full),
      .fifo_clear(clr0)
   );

   fifo_loader #(
      .data_size(data_size), .addr_width(addr_width), .len_width(len_width), .clear_on_start(1'b1)
   ) u_dut_clr (
      .w_clk(w_clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy1), .done(done1), .words_written(ww1), .mem_rd_en(rd_en1), .mem_addr(addr1),
      .mem_rdata(rdata1), .fifo_w_en(w_en1), .fifo_data(fdata1), .fifo_full(fifo_full),
      .fifo_clear(clr1)
   );

   function automatic string q_str(input int q[$]);
      string s = "";
      foreach (q[i]) begin
         if (i > 0) s = {s, ","};
         s = {s, $sformatf("%0d", q[i])};
      end
      return s;
   endfunction

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge w_clk);
      @(posedge w_clk);
      #1;
      reset = 1'b0;
   endtask

   // Runs one burst starting at cycle 0 (the current cycle) and records what the selected
   // instance did; the model tracks words outstanding (issued minus written) to predict each cycle.
   task automatic run_burst(input bit use_clr, input int base, input int len, input int full_mode,
                            input int restart_cyc, input int reset_at_write);
      int  reads, writes, done_at, clr_off;
      bit  prev_rd, in_stream, hold, exp_rd, exp_wen;
      rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete();
      done_cyc.delete(); busy_cyc.delete(); clr_cyc.delete();
      viol_issue = 0; viol_wen = 0; viol_full = 0; viol_data = 0; capt = 0;
      timed_out = 1'b1; reads = 0; writes = 0; prev_rd = 1'b0; done_at = -1;
      clr_off = use_clr ? 1 : 0;
      sel = use_clr;
      for (int c = 0; c < 600; c++) begin
         start = (c == 0) || (c == restart_cyc);
         if (c == 0) begin
            base_addr = addr_width'(base);
            length    = len_width'(len);
         end else if (c == restart_cyc) begin
            base_addr = addr_width'($urandom);
            length    = len_width'($urandom);
         end
         case (full_mode)
            1:       fifo_full = (c >= 3) && (c <= 6);
            2:       fifo_full = (c > 0) && ($urandom_range(0, 2) == 0);
            default: fifo_full = 1'b0;
         endcase
         #2;
         in_stream = (c >= 1 + clr_off) && (writes < len);
         hold      = (reads - writes - int'(prev_rd)) > 0;
         exp_rd    = in_stream && (reads < len) && !hold && !fifo_full;
         exp_wen   = in_stream && !fifo_full && (hold || prev_rd);
         if (o_rd_en !== exp_rd)  viol_issue++;
         if (o_w_en  !== exp_wen) viol_wen++;
         if (o_w_en === 1'b1 && fifo_full) viol_full++;
         if (prev_rd && fifo_full) capt++;
         if (o_rd_en === 1'b1) begin
            rd_cyc.push_back(c);
            rd_addr.push_back(int'(o_addr));
            reads++;
         end
         if (o_w_en === 1'b1) begin
            if (o_fdata !== ram[10'(base + writes)]) viol_data++;
            wr_cyc.push_back(c);
            writes++;
         end
         if (o_clr  === 1'b1) clr_cyc.push_back(c);
         if (o_busy === 1'b1) busy_cyc.push_back(c);
         if (o_done === 1'b1) begin
            done_cyc.push_back(c);
            if (done_at < 0) done_at = c;
         end
         prev_rd  = (o_rd_en === 1'b1);
         ww_final = o_ww;
         if (reset_at_write > 0 && writes == reset_at_write && o_w_en === 1'b1) begin
            reset = 1'b1;
            @(posedge w_clk);
            #1;
            reset = 1'b0; start = 1'b0; fifo_full = 1'b0;
            #2;
            rst_snap  = {o_busy, o_done, o_rd_en, o_w_en, o_clr, o_ww, o_addr, o_fdata};
            timed_out = 1'b0;
            break;
         end
         if (done_at >= 0 && c == done_at + 1) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge w_clk);
         #1;
      end
      start = 1'b0;
      fifo_full = 1'b0;
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset();
      logic [30:0] v0, v1;
      reset = 1'b1;
      repeat (3) @(posedge w_clk);
      #3;
      v0 = {busy0, done0, rd_en0, w_en0, clr0, ww0, addr0, fdata0};
      v1 = {busy1, done1, rd_en1, w_en1, clr1, ww1, addr1, fdata1};
      n_checks++;
      if (v0 !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h, expected 0", v0); end
      n_checks++;
      if (v1 !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs_clr: got %h, expected 0", v1); end
      @(posedge w_clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_burst(1'b0, 'h010, 4, 0, -1, 0);
      n_checks++;
      if (q_str(rd_cyc) != "1,2,3,4") begin n_fail++; $display("[TB] FAIL basic_rd_cycles: got %s, expected 1,2,3,4", q_str(rd_cyc)); end
      n_checks++;
      if (q_str(rd_addr) != "16,17,18,19") begin n_fail++; $display("[TB] FAIL basic_addrs: got %s, expected 16,17,18,19", q_str(rd_addr)); end
      n_checks++;
      if (q_str(wr_cyc) != "2,3,4,5") begin n_fail++; $display("[TB] FAIL basic_wr_cycles: got %s, expected 2,3,4,5", q_str(wr_cyc)); end
      n_checks++;
      if (q_str(done_cyc) != "6") begin n_fail++; $display("[TB] FAIL basic_done: got %s, expected 6", q_str(done_cyc)); end
      n_checks++;
      if (q_str(busy_cyc) != "1,2,3,4,5,6") begin n_fail++; $display("[TB] FAIL basic_busy: got %s, expected 1,2,3,4,5,6", q_str(busy_cyc)); end
      n_checks++;
      if (ww_final !== 8'd4) begin n_fail++; $display("[TB] FAIL basic_words_written: got %0d, expected 4", ww_final); end
      n_checks++;
      if ((viol_issue + viol_wen + viol_data + int'(timed_out)) != 0) begin
         n_fail++; $display("[TB] FAIL basic_protocol: got issue=%0d wen=%0d data=%0d timeout=%0d, expected all 0", viol_issue, viol_wen, viol_data, timed_out);
      end
   endtask

   task automatic test_backpressure();
      run_burst(1'b0, 'h155, 8, 1, -1, 0);
      n_checks++;
      if (capt != 1) begin n_fail++; $display("[TB] FAIL bp_hold_captures: got %0d, expected 1", capt); end
      n_checks++;
      if (viol_full != 0) begin n_fail++; $display("[TB] FAIL bp_write_while_full: got %0d, expected 0", viol_full); end
      n_checks++;
      if (q_str(wr_cyc) != "2,7,9,10,11,12,13,14") begin n_fail++; $display("[TB] FAIL bp_wr_cycles: got %s, expected 2,7,9,10,11,12,13,14", q_str(wr_cyc)); end
      n_checks++;
      if (q_str(done_cyc) != "15") begin n_fail++; $display("[TB] FAIL bp_done: got %s, expected 15", q_str(done_cyc)); end
      n_checks++;
      if ((viol_issue + viol_wen + viol_data + int'(timed_out)) != 0 || ww_final !== 8'd8) begin
         n_fail++; $display("[TB] FAIL bp_protocol: got issue=%0d wen=%0d data=%0d timeout=%0d ww=%0d, expected 0/0/0/0/8", viol_issue, viol_wen, viol_data, timed_out, ww_final);
      end
   endtask

   task automatic test_zero_length();
      run_burst(1'b0, 'h020, 0, 0, -1, 0);
      n_checks++;
      if (q_str(done_cyc) != "1") begin n_fail++; $display("[TB] FAIL zero_done: got %s, expected 1", q_str(done_cyc)); end
      n_checks++;
      if (rd_cyc.size() != 0 || wr_cyc.size() != 0) begin n_fail++; $display("[TB] FAIL zero_traffic: got reads=%0d writes=%0d, expected 0/0", rd_cyc.size(), wr_cyc.size()); end
      n_checks++;
      if (q_str(busy_cyc) != "1") begin n_fail++; $display("[TB] FAIL zero_busy: got %s, expected 1", q_str(busy_cyc)); end
      n_checks++;
      if (ww_final !== 8'd0) begin n_fail++; $display("[TB] FAIL zero_words_written: got %0d, expected 0", ww_final); end
   endtask

   task automatic test_wrap();
      run_burst(1'b0, 'h3FE, 4, 0, -1, 0);
      n_checks++;
      if (q_str(rd_addr) != "1022,1023,0,1") begin n_fail++; $display("[TB] FAIL wrap_addrs: got %s, expected 1022,1023,0,1", q_str(rd_addr)); end
      n_checks++;
      if (viol_data != 0 || wr_cyc.size() != 4) begin n_fail++; $display("[TB] FAIL wrap_data: got bad=%0d writes=%0d, expected 0/4", viol_data, wr_cyc.size()); end
   endtask

   task automatic test_mid_reset();
      run_burst(1'b0, 'h0A0, 6, 0, -1, 3);
      n_checks++;
      if (rst_snap !== '0) begin n_fail++; $display("[TB] FAIL midreset_outputs: got %h, expected 0", rst_snap); end
      n_checks++;
      if (q_str(wr_cyc) != "2,3,4") begin n_fail++; $display("[TB] FAIL midreset_prewrites: got %s, expected 2,3,4", q_str(wr_cyc)); end
      run_burst(1'b0, 'h200, 2, 0, -1, 0);
      n_checks++;
      if (ww_final !== 8'd2 || q_str(done_cyc) != "4") begin n_fail++; $display("[TB] FAIL midreset_rerun: got ww=%0d done=%s, expected ww=2 done=4", ww_final, q_str(done_cyc)); end
      n_checks++;
      if ((viol_issue + viol_wen + viol_data + int'(timed_out)) != 0) begin
         n_fail++; $display("[TB] FAIL midreset_protocol: got issue=%0d wen=%0d data=%0d timeout=%0d, expected all 0", viol_issue, viol_wen, viol_data, timed_out);
      end
   endtask

   task automatic test_start_ignored();
      int base;
      int exp_q[$];
      base = int'($urandom_range(0, 1023));
      for (int i = 0; i < 6; i++) exp_q.push_back((base + i) % 1024);
      run_burst(1'b0, base, 6, 0, 3, 0);
      n_checks++;
      if (q_str(rd_addr) != q_str(exp_q)) begin n_fail++; $display("[TB] FAIL restart_addrs: got %s, expected %s", q_str(rd_addr), q_str(exp_q)); end
      n_checks++;
      if (ww_final !== 8'd6 || q_str(done_cyc) != "8") begin n_fail++; $display("[TB] FAIL restart_counters: got ww=%0d done=%s, expected ww=6 done=8", ww_final, q_str(done_cyc)); end
   endtask

   task automatic test_clear();
      apply_reset();
      run_burst(1'b1, 'h030, 2, 0, -1, 0);
      n_checks++;
      if (q_str(clr_cyc) != "1") begin n_fail++; $display("[TB] FAIL clear_pulse: got %s, expected 1", q_str(clr_cyc)); end
      n_checks++;
      if (q_str(rd_cyc) != "2,3") begin n_fail++; $display("[TB] FAIL clear_rd_cycles: got %s, expected 2,3", q_str(rd_cyc)); end
      n_checks++;
      if (q_str(wr_cyc) != "3,4" || q_str(done_cyc) != "5" || viol_data != 0) begin
         n_fail++; $display("[TB] FAIL clear_writes: got wr=%s done=%s bad=%0d, expected wr=3,4 done=5 bad=0", q_str(wr_cyc), q_str(done_cyc), viol_data);
      end
      apply_reset();
      run_burst(1'b1, 'h040, 0, 0, -1, 0);
      n_checks++;
      if (q_str(done_cyc) != "2" || q_str(clr_cyc) != "1" || rd_cyc.size() != 0) begin
         n_fail++; $display("[TB] FAIL clear_zero: got done=%s clr=%s reads=%0d, expected done=2 clr=1 reads=0", q_str(done_cyc), q_str(clr_cyc), rd_cyc.size());
      end
      apply_reset();
   endtask

   task automatic test_random();
      int base, len;
      for (int i = 0; i < 12; i++) begin
         base = int'($urandom_range(0, 1023));
         len  = int'($urandom_range(1, 40));
         run_burst(1'b0, base, len, 2, -1, 0);
         n_checks++;
         if ((viol_issue + viol_wen + viol_full + viol_data + int'(timed_out)) != 0) begin
            n_fail++; $display("[TB] FAIL rand%0d_protocol: got issue=%0d wen=%0d full=%0d data=%0d timeout=%0d, expected all 0", i, viol_issue, viol_wen, viol_full, viol_data, timed_out);
         end
         n_checks++;
         if (wr_cyc.size() != len || int'(ww_final) != len) begin
            n_fail++; $display("[TB] FAIL rand%0d_count: got writes=%0d ww=%0d, expected %0d", i, wr_cyc.size(), ww_final, len);
         end
         n_checks++;
         if (done_cyc.size() != 1 || wr_cyc.size() == 0 || done_cyc[0] != wr_cyc[$] + 1) begin
            n_fail++; $display("[TB] FAIL rand%0d_done: got done=%s, expected one pulse right after last write", i, q_str(done_cyc));
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; start = 1'b0; fifo_full = 1'b0; sel = 1'b0;
      base_addr = '0; length = '0;
      for (int i = 0; i < 1024; i++) ram[i] = data_size'($urandom);
      $display("[TB] starting fifo_loader bench");
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_length();
      test_wrap();
      test_mid_reset();
      test_start_ignored();
      test_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
